// File: rtl/ts_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_pkg: shared state encoding, queue indices and shaper defaults.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TX    = 2'd2
  } ts_state_e;

  localparam logic [1:0] Q_TSN_EVEN = 2'd0;
  localparam logic [1:0] Q_TSN_ODD  = 2'd1;
  localparam logic [1:0] Q_RSV      = 2'd2;
  localparam logic [1:0] Q_BE       = 2'd3;

  localparam int PKT_LEN_W        = 7;
  localparam int DEF_CREDIT_W     = 12;
  localparam int DEF_IDLE_SLOPE   = 1;
  localparam int DEF_LEN_WEIGHT   = 4;
  localparam int DEF_HI_LIMIT     = 1023;
  localparam int DEF_LO_LIMIT     = -1024;

  function automatic logic [3:0] q_onehot(input logic [1:0] q);
    return 4'b0001 << q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ts_cbs_credit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_cbs_credit: signed saturating credit counter for the q2 shaper.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ts_cbs_credit
  import ts_pkg::*;
#(
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int IDLE_SLOPE = DEF_IDLE_SLOPE,
  parameter int LEN_WEIGHT = DEF_LEN_WEIGHT,
  parameter int HI_LIMIT   = DEF_HI_LIMIT,
  parameter int LO_LIMIT   = DEF_LO_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       q2_empty_i,
  input  logic                       q2_in_service_i,
  input  logic                       debit_i,
  input  logic [PKT_LEN_W-1:0]       pkt_len_i,
  output logic signed [CREDIT_W-1:0] credit_o
);

  localparam int EXT_W = CREDIT_W + 1;
  localparam logic signed [EXT_W-1:0]    C_HI   = EXT_W'(HI_LIMIT);
  localparam logic signed [EXT_W-1:0]    C_LO   = EXT_W'(LO_LIMIT);
  localparam logic signed [CREDIT_W-1:0] C_HI_N = CREDIT_W'(HI_LIMIT);
  localparam logic signed [CREDIT_W-1:0] C_LO_N = CREDIT_W'(LO_LIMIT);

  logic signed [CREDIT_W-1:0] credit_q, credit_d;
  logic signed [EXT_W-1:0]    cur_ext, debit_amt, sum_dn, sum_up;
  logic        [EXT_W-1:0]    len_ext;
  logic                       credit_pos;

  // One extra bit of headroom lets the raw sum be compared against the limits.
  always_comb begin
    cur_ext    = {credit_q[CREDIT_W-1], credit_q};
    len_ext    = EXT_W'(pkt_len_i);
    debit_amt  = $signed(len_ext * EXT_W'(LEN_WEIGHT));
    sum_dn     = cur_ext - debit_amt;
    sum_up     = cur_ext + EXT_W'(IDLE_SLOPE);
    credit_pos = !credit_q[CREDIT_W-1] && (credit_q != '0);

    credit_d = credit_q;
    if (debit_i) begin
      credit_d = (sum_dn < C_LO) ? C_LO_N : sum_dn[CREDIT_W-1:0];
    end else if (!q2_empty_i && !q2_in_service_i) begin
      credit_d = (sum_up > C_HI) ? C_HI_N : sum_up[CREDIT_W-1:0];
    end else if (q2_empty_i && credit_pos) begin
      credit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule
`default_nettype wire

// File: rtl/ts_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ts_sched: four-queue egress scheduler (TSN slot, CBS-shaped, BE).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ts_sched
  import ts_pkg::*;
#(
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int IDLE_SLOPE = DEF_IDLE_SLOPE,
  parameter int LEN_WEIGHT = DEF_LEN_WEIGHT,
  parameter int HI_LIMIT   = DEF_HI_LIMIT,
  parameter int LO_LIMIT   = DEF_LO_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_ts_slot_odd,
  input  logic                 in_ts_gate_en,
  input  logic [3:0]           in_ts_fifo_empty,
  input  logic [3:0]           in_ts_md_outport,
  input  logic [PKT_LEN_W-1:0] in_ts_pkt_len,
  input  logic                 in_ts_tx_rdy,
  input  logic                 in_ts_tx_done,
  output logic [3:0]           out_ts_q_rden,
  output logic [1:0]           out_ts_grant_q,
  output logic                 out_ts_outport,
  output logic                 out_ts_busy,
  output logic [CREDIT_W-1:0]  out_ts_credit
);

  ts_state_e            state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 outport_q, outport_d;
  logic [3:0]           rden_q, rden_d;
  logic [PKT_LEN_W-1:0] len_q, len_d;

  logic [3:0] elig;
  logic       any_elig;
  logic [1:0] win;
  logic       q2_in_service;
  logic       q2_debit;

  always_comb begin
    elig[Q_TSN_EVEN] = !in_ts_fifo_empty[Q_TSN_EVEN] && (!in_ts_gate_en || !in_ts_slot_odd);
    elig[Q_TSN_ODD]  = !in_ts_fifo_empty[Q_TSN_ODD]  && (!in_ts_gate_en ||  in_ts_slot_odd);
    elig[Q_RSV]      = !in_ts_fifo_empty[Q_RSV]      && !out_ts_credit[CREDIT_W-1];
    elig[Q_BE]       = !in_ts_fifo_empty[Q_BE];
    any_elig         = |elig;

    win = Q_BE;
    if (elig[Q_TSN_EVEN]) begin
      win = Q_TSN_EVEN;
    end else if (elig[Q_TSN_ODD]) begin
      win = Q_TSN_ODD;
    end else if (elig[Q_RSV]) begin
      win = Q_RSV;
    end
  end

  // Head fields are only trusted in IDLE; the pop lands at the end of GRANT.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    outport_d = outport_q;
    len_d     = len_q;
    rden_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (in_ts_tx_rdy && any_elig) begin
          state_d   = GRANT;
          gnt_d     = win;
          outport_d = in_ts_md_outport[win];
          rden_d    = q_onehot(win);
          if (win == Q_RSV) begin
            len_d = in_ts_pkt_len;
          end
        end
      end
      GRANT:   state_d = TX;
      TX:      if (in_ts_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      outport_q <= 1'b0;
      rden_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      outport_q <= outport_d;
      rden_q    <= rden_d;
      len_q     <= len_d;
    end
  end

  assign q2_in_service = (state_q != IDLE) && (gnt_q == Q_RSV);
  assign q2_debit      = (state_q == GRANT) && (gnt_q == Q_RSV);

  ts_cbs_credit #(
    .CREDIT_W   (CREDIT_W),
    .IDLE_SLOPE (IDLE_SLOPE),
    .LEN_WEIGHT (LEN_WEIGHT),
    .HI_LIMIT   (HI_LIMIT),
    .LO_LIMIT   (LO_LIMIT)
  ) u_credit (
    .clk             (clk),
    .rst             (rst),
    .q2_empty_i      (in_ts_fifo_empty[Q_RSV]),
    .q2_in_service_i (q2_in_service),
    .debit_i         (q2_debit),
    .pkt_len_i       (len_q),
    .credit_o        (out_ts_credit)
  );

  assign out_ts_q_rden  = rden_q;
  assign out_ts_grant_q = gnt_q;
  assign out_ts_outport = outport_q;
  assign out_ts_busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ts_sched.sv
`default_nettype none
// Randomized scoreboard bench for ts_sched: environment FIFOs, a
// transaction-level reference model, and an independent output monitor.
module tb_ts_sched;

  localparam int CW = 12;
  localparam int LW = 4;
  localparam int HI = 1023;
  localparam int LO = -1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_ts_slot_odd, in_ts_gate_en;
  logic [3:0]    in_ts_fifo_empty, in_ts_md_outport;
  logic [6:0]    in_ts_pkt_len;
  logic          in_ts_tx_rdy, in_ts_tx_done;
  logic [3:0]    out_ts_q_rden;
  logic [1:0]    out_ts_grant_q;
  logic          out_ts_outport, out_ts_busy;
  logic [CW-1:0] out_ts_credit;

  always #5 clk = ~clk;

  ts_sched #(
    .CREDIT_W(CW), .IDLE_SLOPE(1), .LEN_WEIGHT(LW), .HI_LIMIT(HI), .LO_LIMIT(LO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_ts_slot_odd(in_ts_slot_odd), .in_ts_gate_en(in_ts_gate_en),
    .in_ts_fifo_empty(in_ts_fifo_empty), .in_ts_md_outport(in_ts_md_outport),
    .in_ts_pkt_len(in_ts_pkt_len), .in_ts_tx_rdy(in_ts_tx_rdy),
    .in_ts_tx_done(in_ts_tx_done), .out_ts_q_rden(out_ts_q_rden),
    .out_ts_grant_q(out_ts_grant_q), .out_ts_outport(out_ts_outport),
    .out_ts_busy(out_ts_busy), .out_ts_credit(out_ts_credit)
  );

  typedef struct {
    int   q;
    logic op;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] obs[$];
  logic [7:0] fq[4][$];   // bit 7 = outport, [6:0] = length
  int         total = 0;
  int         bad = 0;

  // Reference model: phase 0 = free, 1 = read pulse cycle, 2 = transmitting
  int   m_credit = 0, m_phase = 0, m_gq = 0, m_len = 0;
  logic m_op = 1'b0;
  int   n_credit, n_phase, n_gq, n_len;
  logic n_op;
  bit   n_push;
  exp_t n_exp;

  int   p_push[4];
  int   p_rdy, p_done;
  bit   rnd_gate;
  logic [3:0] pend;

  task automatic check(string name, bit ok, longint act, longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh_heads();
    logic [7:0] h;
    for (int i = 0; i < 4; i++) begin
      in_ts_fifo_empty[i] = (fq[i].size() == 0);
      h = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
      in_ts_md_outport[i] = h[7];
    end
    if (fq[2].size() != 0) begin
      h = fq[2][0];
      in_ts_pkt_len = h[6:0];
    end else begin
      in_ts_pkt_len = 7'($urandom);
    end
  endtask

  task automatic model_step();
    bit         e[4];
    int         win;
    bit         q2_full;
    logic [7:0] h;
    n_push = 0; n_credit = m_credit; n_phase = m_phase;
    n_gq = m_gq; n_op = m_op; n_len = m_len;
    if (rst) begin
      n_credit = 0; n_phase = 0; n_gq = 0; n_op = 1'b0; n_len = 0;
      return;
    end
    q2_full = (fq[2].size() != 0);
    e[0] = (fq[0].size() != 0) && (!in_ts_gate_en || !in_ts_slot_odd);
    e[1] = (fq[1].size() != 0) && (!in_ts_gate_en || in_ts_slot_odd);
    e[2] = q2_full && (m_credit >= 0);
    e[3] = (fq[3].size() != 0);
    if (m_phase == 1 && m_gq == 2) begin
      n_credit = m_credit - m_len * LW;
      if (n_credit < LO) n_credit = LO;
    end else if (q2_full && !(m_phase != 0 && m_gq == 2)) begin
      n_credit = m_credit + 1;
      if (n_credit > HI) n_credit = HI;
    end else if (!q2_full && m_credit > 0) begin
      n_credit = 0;
    end
    case (m_phase)
      0: begin
        win = -1;
        for (int i = 3; i >= 0; i--) if (e[i]) win = i;
        if (in_ts_tx_rdy && win >= 0) begin
          h       = fq[win][0];
          n_phase = 1;
          n_gq    = win;
          n_op    = h[7];
          if (win == 2) n_len = int'(h[6:0]);
          n_push  = 1;
          n_exp   = '{win, h[7]};
        end
      end
      1:       n_phase = 2;
      default: if (in_ts_tx_done) n_phase = 0;
    endcase
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      for (int i = 0; i < 4; i++)
        if ($urandom_range(99) < p_push[i] && fq[i].size() < 8)
          fq[i].push_back(8'($urandom));
      in_ts_tx_rdy  = ($urandom_range(99) < p_rdy);
      in_ts_tx_done = ($urandom_range(99) < p_done);
      if (rnd_gate) begin
        in_ts_gate_en  = 1'($urandom_range(1));
        in_ts_slot_odd = 1'($urandom_range(1));
      end
      refresh_heads();
      model_step();
      pend = out_ts_q_rden;
      @(posedge clk);
      #1;
      m_credit = n_credit; m_phase = n_phase; m_gq = n_gq; m_op = n_op; m_len = n_len;
      if (n_push) sb.push_back(n_exp);
      #2;
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard on read pulses
  int cyc = 0;
  int last_rd = -100;
  always @(posedge clk) begin
    exp_t e;
    int   act_c;
    #2;
    cyc++;
    act_c = int'($signed(out_ts_credit));
    check("credit", act_c == m_credit, act_c, m_credit);
    check("busy", out_ts_busy == (m_phase != 0), out_ts_busy, m_phase != 0);
    check("grant_q", int'(out_ts_grant_q) == m_gq, out_ts_grant_q, m_gq);
    check("outport", out_ts_outport == m_op, out_ts_outport, m_op);
    if (rst) last_rd = -100;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rden", out_ts_q_rden == q_bit(e.q), out_ts_q_rden, q_bit(e.q));
    end else if (out_ts_q_rden != 4'b0) begin
      check("rden_unexpected", 1'b0, out_ts_q_rden, 0);
    end
    if (out_ts_q_rden != 4'b0) begin
      obs.push_back(out_ts_q_rden);
      check("rden_gap", (cyc - last_rd) >= 3, cyc - last_rd, 3);
      last_rd = cyc;
    end
  end

  function automatic logic [3:0] q_bit(int q);
    logic [3:0] one = 4'b0001;
    return one << q;
  endfunction

  task automatic set_knobs(int pp, int rdy, int done);
    for (int i = 0; i < 4; i++) p_push[i] = pp;
    p_rdy = rdy;
    p_done = done;
  endtask

  initial begin
    int c0, c1;
    rst = 1'b1; in_ts_slot_odd = 1'b0; in_ts_gate_en = 1'b0;
    in_ts_fifo_empty = 4'hF; in_ts_md_outport = 4'h0; in_ts_pkt_len = 7'd0;
    in_ts_tx_rdy = 1'b0; in_ts_tx_done = 1'b0; pend = 4'b0; rnd_gate = 0;
    set_knobs(0, 100, 0);
    run(3);
    check("rst_rden", out_ts_q_rden == 4'b0, out_ts_q_rden, 0);
    check("rst_credit", out_ts_credit == '0, out_ts_credit, 0);
    rst = 1'b0;

    // All queues empty with the transmitter idle: nothing may be granted
    run(100);
    check("empty_guard", !out_ts_busy && obs.size() == 0, obs.size(), 0);

    // Slot gating: odd slot serves q1, then even slot serves q0
    set_knobs(0, 100, 100);
    in_ts_gate_en = 1'b1; in_ts_slot_odd = 1'b1;
    fq[0].push_back(8'h80); fq[1].push_back(8'h00);
    obs.delete();
    run(3);
    in_ts_slot_odd = 1'b0;
    run(4);
    check("gate_count", obs.size() == 2, obs.size(), 2);
    if (obs.size() == 2) begin
      check("gate_odd", obs[0] == 4'b0010, obs[0], 2);
      check("gate_even", obs[1] == 4'b0001, obs[1], 1);
    end
    in_ts_gate_en = 1'b0;

    // Back-to-back service: pulses 3 cycles apart, strict priority order
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) fq[i].push_back(8'h01);
    obs.delete();
    run(45);
    check("spacing_count", obs.size() == 12, obs.size(), 12);
    for (int k = 0; k < obs.size() && k < 12; k++)
      check("spacing_order", obs[k] == q_bit(k / 3), obs[k], q_bit(k / 3));

    // Shaper block: q2 len 10 debits 40, then q3 overtakes the negative q2
    fq[2].push_back(8'd10); fq[2].push_back(8'd10); fq[3].push_back(8'h80);
    obs.delete();
    c0 = 0;
    for (int k = 0; k < 20 && out_ts_q_rden != 4'b0100; k++) run(1);
    check("q2_grant_seen", out_ts_q_rden == 4'b0100, out_ts_q_rden, 4);
    c0 = int'($signed(out_ts_credit));
    run(1);
    c1 = int'($signed(out_ts_credit));
    check("q2_debit", c1 == c0 - 40, c1, c0 - 40);
    run(80);
    check("cbs_count", obs.size() == 3, obs.size(), 3);
    if (obs.size() == 3) begin
      check("cbs_first", obs[0] == 4'b0100, obs[0], 4);
      check("cbs_be", obs[1] == 4'b1000, obs[1], 8);
      check("cbs_q2", obs[2] == 4'b0100, obs[2], 4);
    end

    // Saturation while q0 holds the transmitter
    set_knobs(0, 100, 0);
    fq[0].push_back(8'h00); fq[2].push_back(8'h01);
    run(2000);
    check("sat_hi", int'($signed(out_ts_credit)) == HI, $signed(out_ts_credit), HI);
    fq[2].delete();
    run(1);
    check("sat_clear", out_ts_credit == '0, $signed(out_ts_credit), 0);
    p_done = 100;
    run(5);

    // Reset in TX, then a stray completion must not produce a grant
    p_done = 0;
    fq[3].push_back(8'h80);
    run(3);
    check("pre_rst_busy", out_ts_busy == 1'b1, out_ts_busy, 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst_tx_busy", out_ts_busy == 1'b0, out_ts_busy, 0);
    check("rst_tx_rden", out_ts_q_rden == 4'b0, out_ts_q_rden, 0);
    check("rst_tx_credit", out_ts_credit == '0, out_ts_credit, 0);
    obs.delete();
    set_knobs(0, 0, 100);
    run(4);
    check("rst_no_grant", obs.size() == 0, obs.size(), 0);

    // Randomized traffic with slot parity and gating changing freely
    rnd_gate = 1;
    set_knobs(15, 80, 30);
    run(3000);
    rnd_gate = 0;
    set_knobs(0, 100, 50);
    run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
